serial_source: RTL and testbench



---
 rtl/serial_pkg.sv | 19 +
 rtl/serial_bit_counter.sv | 31 +++
 rtl/serial_source.sv | 110 +++++++++++
 tb/tb_serial_source.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial stimulus stage: FSM encodings,
// default word width and the bit-counter width helper.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SHIFT   = 2'b01,
        ST_DONE    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count 0..w-1; never less than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for one serialized word: clear wins over increment,
// and `last` flags the final bit position (WIDTH-1).
module serial_bit_counter
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clock,
    input  logic reset_b,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign last = (count_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_source.sv
// Parallel-to-serial stimulus stage: accepts a word over ready/load and shifts
// it out LSB-first, streaming back-to-back words with no idle gap.
module serial_source
    import serial_pkg::*;
#(
    parameter int   WIDTH  = DEFAULT_WIDTH,
    parameter logic IDLE_X = 1'b0
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             enable,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_done
);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic               x_reg, x_next;
    logic               x_valid_reg, x_valid_next;
    logic               frame_done_reg, frame_done_next;
    logic               cnt_clear, cnt_inc, cnt_last;
    logic               accept;

    serial_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clock   (clock),
        .reset_b (reset_b),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .last    (cnt_last)
    );

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_reg      <= ST_IDLE;
            shift_reg      <= '0;
            x_reg          <= IDLE_X;
            x_valid_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            x_reg          <= x_next;
            x_valid_reg    <= x_valid_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        x_next          = x_reg;
        x_valid_next    = x_valid_reg;
        frame_done_next = frame_done_reg;
        cnt_clear       = 1'b0;
        cnt_inc         = 1'b0;
        ready           = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE: ready = enable;
            ST_SHIFT:         ready = enable & cnt_last;
            default:          ready = 1'b0;
        endcase
        accept = load & ready;

        // With enable low everything, including a pending frame_done, holds.
        if (enable) begin
            frame_done_next = 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_next = ST_SHIFT;
                        shift_next = data_in;
                        cnt_clear  = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_last) begin
                        cnt_clear       = 1'b1;
                        frame_done_next = 1'b1;
                        if (accept) begin
                            shift_next = data_in;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        shift_next = shift_reg >> 1;
                        cnt_inc    = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_clear  = 1'b1;
                end
            endcase
            x_next       = (state_next == ST_SHIFT) ? shift_next[0] : IDLE_X;
            x_valid_next = (state_next == ST_SHIFT);
        end
    end

    assign x          = x_reg;
    assign x_valid    = x_valid_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_serial_source.sv
// Randomized + directed bench for serial_source: accepted words are expanded
// into an expected bit queue which an independent monitor drains and compares.
module tb_serial_source;

    localparam int   W      = 8;
    localparam logic IDLE_X = 1'b0;

    logic         clock = 1'b0;
    logic         reset_b;
    logic [W-1:0] data_in;
    logic         load;
    logic         enable;
    logic         ready;
    logic         x;
    logic         x_valid;
    logic         frame_done;

    int checks   = 0;
    int failures = 0;

    // Expected bit stream: {is_last_bit, bit_value}
    logic [1:0] exp_q[$];
    // Bits of the current word still to be presented, including this cycle's.
    int rem = 0;

    serial_source #(.WIDTH(W), .IDLE_X(IDLE_X)) dut (
        .clock      (clock),
        .reset_b    (reset_b),
        .data_in    (data_in),
        .load       (load),
        .enable     (enable),
        .ready      (ready),
        .x          (x),
        .x_valid    (x_valid),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; entered and left just after a rising edge.
    task automatic step(input logic en, input logic ld, input logic [W-1:0] d);
        logic exp_ready;
        logic acc;
        enable  = en;
        load    = ld;
        data_in = d;
        @(negedge clock);
        exp_ready = en && (rem <= 1);
        check("ready", ready, exp_ready);
        acc = ld && exp_ready;
        @(posedge clock);
        if (acc) begin
            for (int i = 0; i < W; i++) exp_q.push_back({(i == W - 1), d[i]});
            $display("load accepted data=%0h", d);
        end
        if (en) rem = acc ? W : ((rem > 0) ? rem - 1 : 0);
        #1;
    endtask

    task automatic run_to_last_bit();
        int guard = 0;
        while (rem != 1 && guard < 40) begin
            step(1'b1, 1'b0, '0);
            guard++;
        end
        check("reach_last_bit", rem, 1);
    endtask

    task automatic pulse_reset();
        reset_b = 1'b0;
        #1;
        check("rst_x", x, IDLE_X);
        check("rst_x_valid", x_valid, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        exp_q.delete();
        rem = 0;
        @(negedge clock);
        @(posedge clock);
        #1;
        reset_b = 1'b1;
        $display("reset pulsed");
    endtask

    // Monitor: after an enabled edge the next expected bit (or idle) must show;
    // after a disabled edge all outputs must hold.
    initial begin
        logic prev_en, prev_last, held_x, held_v, held_fd;
        logic ex, ev, efd;
        logic [1:0] e;
        prev_en = 1'b1; prev_last = 1'b0;
        held_x = IDLE_X; held_v = 1'b0; held_fd = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_b) begin
                prev_en = 1'b1; prev_last = 1'b0;
                held_x = IDLE_X; held_v = 1'b0; held_fd = 1'b0;
            end else begin
                if (!prev_en) begin
                    check("hold_x", x, held_x);
                    check("hold_x_valid", x_valid, held_v);
                    check("hold_frame_done", frame_done, held_fd);
                end else begin
                    efd = prev_last;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        ex = e[0]; ev = 1'b1; prev_last = e[1];
                    end else begin
                        ex = IDLE_X; ev = 1'b0; prev_last = 1'b0;
                    end
                    check("x", x, ex);
                    check("x_valid", x_valid, ev);
                    check("frame_done", frame_done, efd);
                end
                held_x = x; held_v = x_valid; held_fd = frame_done;
                prev_en = enable;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        reset_b = 1'b0; enable = 1'b1; load = 1'b0; data_in = '0;
        #1;
        check("reset_x", x, IDLE_X);
        check("reset_x_valid", x_valid, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_ready", ready, 1'b1);
        @(posedge clock);
        #1;
        reset_b = 1'b1;

        // Single word, then idle.
        step(1'b1, 1'b1, 8'hB2);
        repeat (W + 3) step(1'b1, 1'b0, '0);

        // Back-to-back: second word loaded during the last bit of the first.
        step(1'b1, 1'b1, 8'h0F);
        run_to_last_bit();
        step(1'b1, 1'b1, 8'hA5);
        repeat (W + 2) step(1'b1, 1'b0, '0);

        // Enable dropped for 3 cycles at bit 3, with a load offered meanwhile.
        step(1'b1, 1'b1, 8'h3C);
        repeat (3) step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 8'h55);
        repeat (2) step(1'b0, 1'b0, '0);
        repeat (W) step(1'b1, 1'b0, '0);

        // Enable low while frame_done is up.
        step(1'b1, 1'b1, 8'hC3);
        run_to_last_bit();
        step(1'b1, 1'b0, '0);
        repeat (2) step(1'b0, 1'b0, '0);
        repeat (2) step(1'b1, 1'b0, '0);

        // Reset mid-word, then a normal word.
        step(1'b1, 1'b1, 8'hFF);
        repeat (5) step(1'b1, 1'b0, '0);
        pulse_reset();
        step(1'b1, 1'b1, 8'h01);
        repeat (W + 2) step(1'b1, 1'b0, '0);

        // Loads during bits 0..6 of an active word are dropped.
        step(1'b1, 1'b1, 8'h96);
        repeat (W - 1) step(1'b1, 1'b1, W'($urandom));
        repeat (3) step(1'b1, 1'b0, '0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0), W'($urandom));
        end

        guard = 0;
        while (rem != 0 && guard < 100) begin
            step(1'b1, 1'b0, '0);
            guard++;
        end
        repeat (2) step(1'b1, 1'b0, '0);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
